// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
// Architectural HI/LO register pair that sits beside the ALU in EX. It also
// contains an iterative radix-2 restoring divider for DIV/DIVU. The divider
// writes remainder->HI and quotient->LO.
//
// Ports
//   Clk, Rst      rising-edge clock, asynchronous active-low reset
//   HiLoEn        64-bit write strobe from the ALU (MULT/MULTU/MADD/MSUB)
//   HiLoWrite     ALU write data, [2W-1:W] -> HI, [W-1:0] -> LO
//   HiLoRead      registered {HI,LO}
//   MthiEn/MtloEn write MoveData into HI / LO (independent of each other)
//   MoveData      MTHI/MTLO source
//   DivStart      start a divide (IDLE only); DivSigned/DivA/DivB are
//                 sampled with it
//   Busy          divide in flight, pipeline must hold
//   DivDone       one-cycle pulse, result committed
//   DivByZero     one-cycle pulse with DivDone when the divisor was zero
//   WriteDropped  one-cycle pulse, a write/start was discarded last cycle
// -----------------------------------------------------------------------------
module hilo_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter bit DIVZERO_KEEP = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    HiLoEn,
  input  logic [2*DATA_WIDTH-1:0] HiLoWrite,
  output logic [2*DATA_WIDTH-1:0] HiLoRead,
  input  logic                    MthiEn,
  input  logic                    MtloEn,
  input  logic [DATA_WIDTH-1:0]   MoveData,
  input  logic                    DivStart,
  input  logic                    DivSigned,
  input  logic [DATA_WIDTH-1:0]   DivA,
  input  logic [DATA_WIDTH-1:0]   DivB,
  output logic                    Busy,
  output logic                    DivDone,
  output logic                    DivByZero,
  output logic                    WriteDropped
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       hi_q, hi_d;
  logic [W-1:0]       lo_q, lo_d;
  logic [W-1:0]       rem_q, rem_d;      // partial remainder (always < divisor)
  logic [W-1:0]       quot_q, quot_d;    // dividend shifts out, quotient shifts in
  logic [W-1:0]       div_q, div_d;      // divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               zero_q, zero_d;
  logic               dropped_q, dropped_d;

  // Operand magnitudes. 0x80000000 maps onto itself, which is the correct
  // unsigned magnitude, so W bits are enough.
  logic         a_neg, b_neg;
  logic [W-1:0] abs_a, abs_b;

  assign a_neg = DivSigned & DivA[W-1];
  assign b_neg = DivSigned & DivB[W-1];
  assign abs_a = a_neg ? (~DivA + 1'b1) : DivA;
  assign abs_b = b_neg ? (~DivB + 1'b1) : DivB;

  // One restoring step. The shifted remainder needs W+1 bits. The kept
  // difference is always below the divisor, so W bits of it suffice.
  logic [W:0]   rem_shift;
  logic [W-1:0] trial;
  logic         fits;

  assign rem_shift = {rem_q, quot_q[W-1]};
  assign fits      = (rem_shift >= {1'b0, div_q});
  assign trial     = rem_shift[W-1:0] - div_q;

  logic any_write;
  assign any_write = HiLoEn | MthiEn | MtloEn;

  // NOTE: every variable written here gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    zero_d    = zero_q;
    dropped_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (DivStart) begin
          // A start takes the cycle. Any write arriving with it is lost.
          dropped_d = any_write;
          rem_d     = '0;
          quot_d    = abs_a;
          div_d     = abs_b;
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
          cnt_d     = CNT_W'(W - 1);
          if (DivB == '0) begin
            zero_d  = 1'b1;
            state_d = S_DONE;
            // The result is written on the start edge, so it is already
            // visible while DivDone is high.
            if (!DIVZERO_KEEP) begin
              hi_d = DivA;
              lo_d = '1;
            end
          end else begin
            zero_d  = 1'b0;
            state_d = S_RUN;
          end
        end else if (HiLoEn) begin
          hi_d = HiLoWrite[2*W-1:W];
          lo_d = HiLoWrite[W-1:0];
        end else begin
          if (MthiEn) hi_d = MoveData;
          if (MtloEn) lo_d = MoveData;
        end
      end

      S_RUN: begin
        dropped_d = any_write | DivStart;
        rem_d     = fits ? trial : rem_shift[W-1:0];
        quot_d    = {quot_q[W-2:0], fits};
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end

      S_FIX: begin
        dropped_d = any_write | DivStart;
        hi_d      = r_neg_q ? (~rem_q + 1'b1)  : rem_q;
        lo_d      = q_neg_q ? (~quot_q + 1'b1) : quot_q;
        state_d   = S_DONE;
      end

      S_DONE: begin
        dropped_d = any_write | DivStart;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      zero_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      zero_q    <= zero_d;
      dropped_q <= dropped_d;
    end
  end

  assign HiLoRead     = {hi_q, lo_q};
  assign Busy         = (state_q != S_IDLE);
  assign DivDone      = (state_q == S_DONE);
  assign DivByZero    = (state_q == S_DONE) & zero_q;
  assign WriteDropped = dropped_q;

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
// Self-checking bench for hilo_unit (DATA_WIDTH=32, DIVZERO_KEEP=1).
// Divide results are pushed to a scoreboard when a divide is started. They
// are popped and compared when the DUT pulses DivDone. Cycle-exact corner
// cases are checked by the hand-written sequences.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        HiLoEn;
  logic [63:0] HiLoWrite;
  logic [63:0] HiLoRead;
  logic        MthiEn, MtloEn;
  logic [31:0] MoveData;
  logic        DivStart, DivSigned;
  logic [31:0] DivA, DivB;
  logic        Busy, DivDone, DivByZero, WriteDropped;

  hilo_unit #(.DATA_WIDTH(32), .DIVZERO_KEEP(1'b1)) dut (
    .Clk(Clk), .Rst(Rst),
    .HiLoEn(HiLoEn), .HiLoWrite(HiLoWrite), .HiLoRead(HiLoRead),
    .MthiEn(MthiEn), .MtloEn(MtloEn), .MoveData(MoveData),
    .DivStart(DivStart), .DivSigned(DivSigned), .DivA(DivA), .DivB(DivB),
    .Busy(Busy), .DivDone(DivDone), .DivByZero(DivByZero),
    .WriteDropped(WriteDropped)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] hilo;
    logic        zero;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, hi, lo;
    logic        zero;   // zero divisor: HI/LO expected unchanged
  } vec_t;
  vec_t vecs[11];

  logic [63:0] model;   // bench's view of {HI,LO}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference divide on 64-bit magnitudes: truncating quotient, and a
  // remainder that takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ma, mb, q, r;
    ma = {32'd0, a};
    mb = {32'd0, b};
    if (sgn && a[31]) ma = 64'd0 - {32'hFFFFFFFF, a};
    if (sgn && b[31]) mb = 64'd0 - {32'hFFFFFFFF, b};
    q = ma / mb;
    r = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = 64'd0 - q;
    if (sgn && a[31])           r = 64'd0 - r;
    return {r[31:0], q[31:0]};
  endfunction

  // Scoreboard monitor: compare on every committed divide.
  always @(negedge Clk) begin
    if (Rst && DivDone) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done: got DivDone=1 expected no pending divide");
      end else begin
        sb_e = sb.pop_front();
        check("div_hilo", HiLoRead, sb_e.hilo);
        check("div_zero", {63'd0, DivByZero}, {63'd0, sb_e.zero});
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 60 && Busy; n++) tick();
    check("div_timeout_busy", {63'd0, Busy}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input logic exp_zero);
    sb.push_back('{exp, exp_zero});
    model     = exp;
    DivStart  = 1'b1;
    DivSigned = sgn;
    DivA      = a;
    DivB      = b;
    tick();
    DivStart  = 1'b0;
    // Scrambled operands during RUN must have no effect.
    DivA      = $urandom;
    DivB      = $urandom;
    wait_idle();
  endtask

  logic [63:0] held;
  logic        seen_bad;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   1'b0};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[3]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   1'b0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   1'b0};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          32'd1,          1'b0};
    vecs[6]  = '{1'b0, 32'd5,          32'd9,          32'd5,          32'd0,          1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd14,         1'b0};
    vecs[8]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[9]  = '{1'b1, 32'h80000000,   32'd1,          32'd0,          32'h80000000,   1'b0};
    vecs[10] = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          1'b1};

    Rst = 1'b0;
    HiLoEn = 1'b0; HiLoWrite = '0;
    MthiEn = 1'b0; MtloEn = 1'b0; MoveData = '0;
    DivStart = 1'b0; DivSigned = 1'b0; DivA = '0; DivB = '0;
    model = '0;
    repeat (3) tick();
    Rst = 1'b1;
    tick();

    // Reset state
    check("rst_hilo", HiLoRead, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, DivDone}, 64'd0);
    check("rst_dropped", {63'd0, WriteDropped}, 64'd0);

    // 64-bit ALU write
    HiLoEn = 1'b1; HiLoWrite = 64'h00000001_FFFFFFFE;
    tick();
    HiLoEn = 1'b0;
    check("hilo_write", HiLoRead, 64'h00000001_FFFFFFFE);
    check("hilo_write_busy", {63'd0, Busy}, 64'd0);

    // MTHI + MTLO in the same cycle
    MthiEn = 1'b1; MtloEn = 1'b1; MoveData = 32'hDEADBEEF;
    tick();
    MtloEn = 1'b0;
    check("mthi_mtlo", HiLoRead, 64'hDEADBEEF_DEADBEEF);
    // HiLoEn beats MTHI
    HiLoEn = 1'b1; HiLoWrite = 64'd0; MoveData = 32'h11111111;
    tick();
    HiLoEn = 1'b0; MthiEn = 1'b0;
    check("hiloen_wins", HiLoRead, 64'd0);
    // MTLO alone
    MtloEn = 1'b1; MoveData = 32'h0000ABCD;
    tick();
    MtloEn = 1'b0;
    check("mtlo_only", HiLoRead, 64'h00000000_0000ABCD);
    HiLoEn = 1'b1; HiLoWrite = 64'd0;
    tick();
    HiLoEn = 1'b0;
    model = 64'd0;

    // DIVU 100/7 cycle by cycle
    sb.push_back('{64'h00000002_0000000E, 1'b0});
    DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd100; DivB = 32'd7;
    tick();                                   // edge 0
    DivStart = 1'b0; DivA = 32'hFFFF0000; DivB = 32'd3;
    check("div_busy_e0", {63'd0, Busy}, 64'd1);
    seen_bad = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (!Busy || DivDone || HiLoRead != 64'd0) seen_bad = 1'b1;
    end
    check("div_run_quiet", {63'd0, seen_bad}, 64'd0);
    tick();                                   // edge 33
    check("div_e33_hilo", HiLoRead, 64'h00000002_0000000E);
    check("div_e33_done", {63'd0, DivDone}, 64'd1);
    check("div_e33_busy", {63'd0, Busy}, 64'd1);
    tick();                                   // edge 34
    check("div_e34_busy", {63'd0, Busy}, 64'd0);
    check("div_e34_done", {63'd0, DivDone}, 64'd0);
    check("sb_drained_100_7", 64'(sb.size()), 64'd0);
    model = 64'h00000002_0000000E;

    // Divide by zero with preset HI/LO
    HiLoEn = 1'b1; HiLoWrite = 64'h12345678_9ABCDEF0;
    tick();
    HiLoEn = 1'b0;
    model = 64'h12345678_9ABCDEF0;
    sb.push_back('{model, 1'b1});
    DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd5; DivB = 32'd0;
    tick();
    DivStart = 1'b0;
    check("dz_done", {63'd0, DivDone}, 64'd1);
    check("dz_flag", {63'd0, DivByZero}, 64'd1);
    check("dz_busy", {63'd0, Busy}, 64'd1);
    check("dz_hilo", HiLoRead, 64'h12345678_9ABCDEF0);
    tick();
    check("dz_busy_fall", {63'd0, Busy}, 64'd0);
    check("dz_done_fall", {63'd0, DivDone}, 64'd0);

    // DivStart together with HiLoEn in IDLE: start wins, write dropped
    held = HiLoRead;
    sb.push_back('{64'h00000000_0000000A, 1'b0});
    DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd50; DivB = 32'd5;
    HiLoEn = 1'b1; HiLoWrite = 64'hAAAAAAAA_55555555;
    tick();
    DivStart = 1'b0; HiLoEn = 1'b0;
    check("start_drop_pulse", {63'd0, WriteDropped}, 64'd1);
    check("start_drop_hilo", HiLoRead, held);
    tick();
    check("start_drop_clear", {63'd0, WriteDropped}, 64'd0);
    wait_idle();
    model = 64'h00000000_0000000A;

    // Table of divides
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].zero)
        run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, model, 1'b1);
      else
        run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1'b0);
    end

    // Random divides against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (rb == 32'd0) rb = 32'd1;
      if (i % 4 == 1) ra = 32'($urandom_range(0, 1000));
      rs = i[0] ^ i[1];
      run_div(rs, ra, rb, ref_div(rs, ra, rb), 1'b0);
    end

    // Writes while busy, then async reset mid-divide
    HiLoEn = 1'b1; HiLoWrite = 64'h0BADF00D_CAFEF00D;
    tick();
    HiLoEn = 1'b0;
    model = 64'h0BADF00D_CAFEF00D;
    DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd1000; DivB = 32'd3;
    tick();                                   // edge 0
    DivStart = 1'b0;
    repeat (2) tick();                        // edges 1..2
    HiLoEn = 1'b1; HiLoWrite = 64'hFFFFFFFF_FFFFFFFF;
    tick();                                   // edge 3
    HiLoEn = 1'b0;
    check("busy_drop_pulse", {63'd0, WriteDropped}, 64'd1);
    check("busy_drop_hilo", HiLoRead, model);
    tick();                                   // edge 4
    check("busy_drop_clear", {63'd0, WriteDropped}, 64'd0);
    DivStart = 1'b1; DivA = 32'd7; DivB = 32'd7;
    tick();                                   // edge 5
    DivStart = 1'b0;
    check("busy_start_drop", {63'd0, WriteDropped}, 64'd1);
    check("busy_start_still_busy", {63'd0, Busy}, 64'd1);
    repeat (5) tick();                        // edges 6..10
    #2;
    Rst = 1'b0;
    #1;
    check("async_rst_hilo", HiLoRead, 64'd0);
    check("async_rst_busy", {63'd0, Busy}, 64'd0);
    tick();
    Rst = 1'b1;
    model = 64'd0;
    tick();
    check("post_rst_idle", {63'd0, Busy}, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);
    check("final_hilo", HiLoRead, 64'h00000000_00000003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Holds the architectural HI/LO pair: accepts the ALU's 64-bit HiLo write port and returns the current value on its HiLo read port.
- Also performs MTHI/MTLO writes.
- Contains an iterative restoring divider (DIV/DIVU) that writes remainder→HI, quotient→LO.
- Sits beside the ALU in EX; Busy stalls the pipeline while a divide is in flight.

Parameters:
- DATA_WIDTH, 32, width of HI and LO each; HiLoRead/HiLoWrite are 2*DATA_WIDTH.
- DIVZERO_KEEP, 1
  - 1: divide-by-zero leaves HI/LO unchanged.
  - 0: divide-by-zero writes HI=dividend, LO=all ones.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- HiLoEn  in  1  ALU 64-bit write strobe (MULT/MULTU/MADD/MSUB)
- HiLoWrite  in  64  ALU write data; [63:32]→HI, [31:0]→LO
- HiLoRead  out  64  registered {HI,LO}, fed back to ALU and to MFHI/MFLO
- MthiEn  in  1  write MoveData to HI
- MtloEn  in  1  write MoveData to LO
- MoveData  in  32  MTHI/MTLO source (rs)
- DivStart  in  1  start divide, sampled in IDLE only
- DivSigned  in  1  1=DIV, 0=DIVU; sampled with DivStart
- DivA  in  32  dividend, sampled with DivStart
- DivB  in  32  divisor, sampled with DivStart
- Busy  out  1  divide in progress; pipeline must hold
- DivDone  out  1  one-cycle pulse when divide result is committed
- DivByZero  out  1  one-cycle pulse, coincident with DivDone, when DivB was 0
- WriteDropped  out  1  one-cycle pulse when a HiLoEn/Mthi/Mtlo arrived while Busy

Behaviour:
- Reset (Rst=0, async):
  - HI=LO=0.
  - State=IDLE.
  - Busy, DivDone, DivByZero, WriteDropped = 0.
  - Divider registers cleared.
  - Any in-flight divide is discarded.
- HiLoRead is a direct register output. A write at edge N is visible after edge N. There is no combinational bypass of write data.
- Write priority in IDLE, same edge:
  - DivStart wins; other writes that cycle are dropped and WriteDropped pulses.
  - Otherwise HiLoEn writes all 64 bits; Mthi/Mtlo that cycle are ignored.
  - Otherwise MthiEn and MtloEn act independently; both may write in the same cycle.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - DivStart with DivB≠0 → RUN.
    - Latch DivSigned.
    - Latch |DivA| and |DivB| (magnitudes when signed, raw when unsigned).
    - Record the quotient sign (A[31]^B[31]) and remainder sign (A[31]); signs are forced to 0 when unsigned.
    - Load iteration counter = 31.
  - DivStart with DivB=0 → DONE directly, with the zero flag set.
- RUN:
  - Each edge performs one restoring step: shift {rem,quot} left by 1, trial-subtract the divisor, keep the result if non-negative, set the quotient LSB.
  - Counter decrements each step; exit to FIX after 32 steps.
- FIX:
  - Negate the quotient if its sign bit is set.
  - Negate the remainder if its sign bit is set.
  - Write HI=remainder, LO=quotient on this edge → DONE.
- DONE:
  - DivDone=1 for exactly one cycle; DivByZero=1 too if the zero flag is set.
  - For divide-by-zero, HI/LO are handled per DIVZERO_KEEP.
  - Next edge → IDLE.
- Busy=1 in RUN, FIX and DONE, and 0 in IDLE. DivStart must be sampled high the next cycle for a new divide to begin.
- Latency for a non-zero divisor:
  - DivStart sampled at edge 0.
  - HiLoRead holds the result after edge 33.
  - DivDone is high in the cycle following edge 33.
  - Busy falls after edge 34.
- Latency for a zero divisor: DivDone/DivByZero are high after edge 0, and Busy falls after edge 1.
- Arithmetic rules:
  - Signed quotient truncates toward zero; signed remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0. There is no trap.
  - The 0x80000000 magnitude must be handled as 33-bit-safe unsigned.
- Writes while Busy:
  - HiLoEn, MthiEn, MtloEn or DivStart in RUN/FIX/DONE are ignored.
  - WriteDropped pulses the following cycle.
  - HI/LO are untouched.
- DivA/DivB changing during RUN has no effect; the operands are latched.

Test Plan:
- Reset, then HiLoEn=1, HiLoWrite=0x00000001_FFFFFFFE → HiLoRead=0x00000001FFFFFFFE after that edge; Busy stays 0.
- MthiEn=MtloEn=1, MoveData=0xDEADBEEF → HiLoRead=0xDEADBEEFDEADBEEF. Next cycle HiLoEn and MthiEn are both high with HiLoWrite=0 → HiLoRead=0 (HiLoEn wins).
- DIVU 100/7 started at edge 0:
  - Busy high after edge 0.
  - After edge 33: HI=2, LO=14, with DivDone pulse.
  - Busy low after edge 34.
- DIV signed:
  - -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide-by-zero: DIVU 5/0 with HI/LO=0x12345678_9ABCDEF0 and DIVZERO_KEEP=1 → DivDone=DivByZero=1 one cycle after start; HI/LO unchanged.
- Start DIVU 1000/3 and assert HiLoEn mid-RUN → WriteDropped pulses and HI/LO keep their prior value. Drop Rst at step 10 → HI=LO=0 and Busy=0 immediately. After release, a new DIVU 9/3 yields HI=0, LO=3.
